// File: rtl/cache_ctrl_nway_pf_if.sv
// CPU/memory/array-control bundle between the cache controller FSM and its
// surroundings: the CPU port, physical memory, the cache datapath and the
// replacement-policy block. The controller takes the slave side.
interface cache_ctrl_nway_pf_if #(
  parameter int WAYS  = 2,
  parameter int CNT_W = 16
);
  localparam int WIDX = (WAYS > 1) ? $clog2(WAYS) : 1;

  // CPU side
  logic             req;
  logic             readwrite;
  logic             cpu_resp;
  // per-way status for the currently selected address
  logic [WAYS-1:0]  hit;
  logic [WAYS-1:0]  valid;
  logic [WAYS-1:0]  dirty;
  // replacement block
  logic [WIDX-1:0]  victim_way;
  logic             lru_update;
  logic [WIDX-1:0]  lru_way;
  // physical memory
  logic             pmem_resp;
  logic             pmem_read;
  logic             pmem_write;
  // array write enables and data selects
  logic [WAYS-1:0]  data_writeline;
  logic [WAYS-1:0]  tag_write;
  logic [WAYS-1:0]  valid_write;
  logic [WAYS-1:0]  dirty_write;
  logic             valid_in;
  logic             dirty_in;
  logic             wb_sel;
  // address path
  logic [1:0]       adr_sel;
  logic             load_adr;
  logic             pf_load;
  logic             pf_inc;
  // performance counters
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
  logic [CNT_W-1:0] pf_count;

  modport slave (
    input  req, readwrite, hit, valid, dirty, victim_way, pmem_resp,
    output cpu_resp, pmem_read, pmem_write,
           data_writeline, tag_write, valid_write, dirty_write,
           valid_in, dirty_in, wb_sel, lru_update, lru_way,
           adr_sel, load_adr, pf_load, pf_inc,
           hit_count, miss_count, pf_count
  );

  modport master (
    output req, readwrite, hit, valid, dirty, victim_way, pmem_resp,
    input  cpu_resp, pmem_read, pmem_write,
           data_writeline, tag_write, valid_write, dirty_write,
           valid_in, dirty_in, wb_sel, lru_update, lru_way,
           adr_sel, load_adr, pf_load, pf_inc,
           hit_count, miss_count, pf_count
  );
endinterface

// File: rtl/cache_ctrl_nway_pf.sv
// Control FSM for a WAYS-way set-associative, write-back, write-allocate
// cache with saturating hit/miss/prefetch counters.
// Build option: define CACHE_PF_EN to compile in sequential next-line
// prefetch of PF_DEPTH lines after each demand miss; without it the
// controller is pure demand-fetch and pf_load/pf_inc/pf_count are 0.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | serve hits, detect misses, start prefetch when CPU is idle
// WB       | write the dirty fill-way line back to memory
// STALL    | switch the memory address back to the CPU line
// FILL     | read the demand line into the fill way
// DONE     | count the miss, arm prefetch, return to IDLE for the hit
// PF_CHECK | probe the prefetch line; skip it if already present
// PF_WB    | write back the dirty fill way ahead of a prefetch
// PF_STALL | switch the memory address to the prefetch line
// PF_FILL  | read the prefetch line (no replacement touch)
module cache_ctrl_nway_pf #(
  parameter int WAYS     = 2,
  parameter int PF_DEPTH = 2,
  parameter int CNT_W    = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  cache_ctrl_nway_pf_if.slave bus
);
  localparam int WIDX = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Parameter sanity: associativity a power of two >= 2, prefetch depth 1..7.
  if (WAYS < 2 || (WAYS & (WAYS - 1)) != 0 || PF_DEPTH < 1 || PF_DEPTH > 7) begin : g_bad_param
    $error("cache_ctrl_nway_pf: illegal WAYS or PF_DEPTH");
  end

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WB       = 4'd1,
    S_STALL    = 4'd2,
    S_FILL     = 4'd3,
    S_DONE     = 4'd4
`ifdef CACHE_PF_EN
    ,
    S_PF_CHECK = 4'd5,
    S_PF_WB    = 4'd6,
    S_PF_STALL = 4'd7,
    S_PF_FILL  = 4'd8
`endif
  } state_e;

  state_e           state_q, state_d;
  logic             refill_q, refill_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [WIDX-1:0]  fill_way, hit_way;
  logic [WAYS-1:0]  fill_oh, hit_oh;
  logic             fill_dirty, any_hit;

  logic             cpu_resp, pmem_read, pmem_write;
  logic [WAYS-1:0]  data_wl, tag_wr, valid_wr, dirty_wr;
  logic             valid_in, dirty_in, wb_sel, lru_update, load_adr;
  logic [WIDX-1:0]  lru_way;
  logic [1:0]       adr_sel;
  logic             hit_inc, miss_inc, refill_set;

`ifdef CACHE_PF_EN
  logic [2:0]       pf_left_q, pf_left_d;
  logic [CNT_W-1:0] pf_cnt_q, pf_cnt_d;
  logic             pf_load, pf_inc, pf_arm, pf_clr, pf_dec, pf_cnt_inc;
`endif

  // Fill way: lowest-index invalid way, otherwise the replacement victim.
  always_comb begin
    logic found;
    found    = 1'b0;
    fill_way = bus.victim_way;
    for (int i = 0; i < WAYS; i++) begin
      if (!found && !bus.valid[i]) begin
        fill_way = WIDX'(i);
        found    = 1'b1;
      end
    end
    fill_oh    = WAYS'(1) << fill_way;
    fill_dirty = bus.dirty[fill_way];
  end

  // Hit way encoder; lowest index wins if the datapath ever reports two.
  always_comb begin
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (bus.hit[i]) hit_way = WIDX'(i);
    end
    hit_oh  = WAYS'(1) << hit_way;
    any_hit = |bus.hit;
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    cpu_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    data_wl    = '0;
    tag_wr     = '0;
    valid_wr   = '0;
    dirty_wr   = '0;
    valid_in   = 1'b0;
    dirty_in   = 1'b0;
    wb_sel     = 1'b0;
    lru_update = 1'b0;
    lru_way    = '0;
    adr_sel    = 2'd0;
    load_adr   = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    refill_set = 1'b0;
`ifdef CACHE_PF_EN
    pf_load    = 1'b0;
    pf_inc     = 1'b0;
    pf_arm     = 1'b0;
    pf_clr     = 1'b0;
    pf_dec     = 1'b0;
    pf_cnt_inc = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          if (any_hit) begin
            cpu_resp   = 1'b1;
            lru_update = 1'b1;
            lru_way    = hit_way;
            // the hit that completes a refill is not a real hit
            hit_inc    = !refill_q;
            if (bus.readwrite) begin
              wb_sel   = 1'b1;
              dirty_in = 1'b1;
              data_wl  = hit_oh;
              dirty_wr = hit_oh;
            end
          end else begin
            load_adr = 1'b1;
`ifdef CACHE_PF_EN
            pf_clr   = 1'b1;
`endif
            if (fill_dirty) begin
              adr_sel = 2'd1;
              state_d = S_WB;
            end else begin
              state_d = S_FILL;
            end
          end
        end
`ifdef CACHE_PF_EN
        else if (pf_left_q != 3'd0) begin
          state_d = S_PF_CHECK;
        end
`endif
      end
      S_WB: begin
        pmem_write = 1'b1;
        adr_sel    = 2'd1;
        if (bus.pmem_resp) state_d = S_STALL;
      end
      S_STALL: begin
        load_adr = 1'b1;
        state_d  = S_FILL;
      end
      S_FILL: begin
        pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          data_wl    = fill_oh;
          tag_wr     = fill_oh;
          valid_wr   = fill_oh;
          dirty_wr   = fill_oh;
          valid_in   = 1'b1;
          lru_update = 1'b1;
          lru_way    = fill_way;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        miss_inc   = 1'b1;
        refill_set = 1'b1;
`ifdef CACHE_PF_EN
        pf_load    = 1'b1;
        pf_arm     = 1'b1;
`endif
        state_d    = S_IDLE;
      end
`ifdef CACHE_PF_EN
      S_PF_CHECK: begin
        adr_sel = 2'd2;
        if (any_hit) begin
          pf_inc  = 1'b1;
          pf_dec  = 1'b1;
          state_d = S_IDLE;
        end else if (fill_dirty) begin
          load_adr = 1'b1;
          adr_sel  = 2'd1;
          state_d  = S_PF_WB;
        end else begin
          load_adr = 1'b1;
          state_d  = S_PF_FILL;
        end
      end
      S_PF_WB: begin
        pmem_write = 1'b1;
        adr_sel    = 2'd1;
        if (bus.pmem_resp) state_d = S_PF_STALL;
      end
      S_PF_STALL: begin
        load_adr = 1'b1;
        adr_sel  = 2'd2;
        state_d  = S_PF_FILL;
      end
      S_PF_FILL: begin
        pmem_read = 1'b1;
        adr_sel   = 2'd2;
        if (bus.pmem_resp) begin
          // no lru_update: prefetched lines stay first in line for eviction
          data_wl    = fill_oh;
          tag_wr     = fill_oh;
          valid_wr   = fill_oh;
          dirty_wr   = fill_oh;
          valid_in   = 1'b1;
          pf_cnt_inc = 1'b1;
          pf_inc     = 1'b1;
          pf_dec     = 1'b1;
          state_d    = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Bookkeeping next values: refill marker and saturating counters.
  always_comb begin
    refill_d   = cpu_resp ? 1'b0 : (refill_set ? 1'b1 : refill_q);
    hit_cnt_d  = (hit_inc && hit_cnt_q != '1) ? hit_cnt_q + 1'b1 : hit_cnt_q;
    miss_cnt_d = (miss_inc && miss_cnt_q != '1) ? miss_cnt_q + 1'b1 : miss_cnt_q;
  end

  // State, refill marker and demand counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      refill_q   <= refill_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

`ifdef CACHE_PF_EN
  // Prefetch budget: cleared by a new demand miss, reloaded after a refill.
  always_comb begin
    pf_left_d = pf_left_q;
    if (pf_clr)                           pf_left_d = 3'd0;
    else if (pf_arm)                      pf_left_d = 3'(PF_DEPTH);
    else if (pf_dec && pf_left_q != 3'd0) pf_left_d = pf_left_q - 3'd1;
    pf_cnt_d = (pf_cnt_inc && pf_cnt_q != '1) ? pf_cnt_q + 1'b1 : pf_cnt_q;
  end

  // Prefetch budget and prefetch counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_left_q <= 3'd0;
      pf_cnt_q  <= '0;
    end else begin
      pf_left_q <= pf_left_d;
      pf_cnt_q  <= pf_cnt_d;
    end
  end

  assign bus.pf_load  = pf_load;
  assign bus.pf_inc   = pf_inc;
  assign bus.pf_count = pf_cnt_q;
`else
  assign bus.pf_load  = 1'b0;
  assign bus.pf_inc   = 1'b0;
  assign bus.pf_count = '0;
`endif

  assign bus.cpu_resp       = cpu_resp;
  assign bus.pmem_read      = pmem_read;
  assign bus.pmem_write     = pmem_write;
  assign bus.data_writeline = data_wl;
  assign bus.tag_write      = tag_wr;
  assign bus.valid_write    = valid_wr;
  assign bus.dirty_write    = dirty_wr;
  assign bus.valid_in       = valid_in;
  assign bus.dirty_in       = dirty_in;
  assign bus.wb_sel         = wb_sel;
  assign bus.lru_update     = lru_update;
  assign bus.lru_way        = lru_way;
  assign bus.adr_sel        = adr_sel;
  assign bus.load_adr       = load_adr;
  assign bus.hit_count      = hit_cnt_q;
  assign bus.miss_count     = miss_cnt_q;
endmodule

// File: tb/tb_cache_ctrl_nway_pf.sv
// Bench for cache_ctrl_nway_pf (WAYS=4, PF_DEPTH=2, CNT_W=6). The bench
// emulates one cache set plus memory around the controller and compares the
// outcome of every CPU request against a transaction-level cache model.
module tb_cache_ctrl_nway_pf;
  localparam int WAYS     = 4;
  localparam int PF_DEPTH = 2;
  localparam int CNT_W    = 6;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  cache_ctrl_nway_pf_if #(.WAYS(WAYS), .CNT_W(CNT_W)) bus ();

  cache_ctrl_nway_pf #(.WAYS(WAYS), .PF_DEPTH(PF_DEPTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // set emulation (what the controller actually wrote)
  int          env_tag[WAYS];
  logic [3:0]  env_vld = '0;
  logic [3:0]  env_dty = '0;
  int          cpu_tag = 0;
  int          pf_tag  = 0;
  int          cur_tag;
  bit          mem_hold = 1'b0;
  int          n_rd = 0, n_wr = 0, rd_cyc = 0, wr_cyc = 0;
  int          lru_cnt = 0, pfinc_cnt = 0;

  // reference model (what a correct cache would hold)
  int          m_tag[WAYS];
  bit          m_vld[WAYS];
  bit          m_dty[WAYS];
  int          exp_hits = 0, exp_miss = 0, exp_pf = 0;

  always_comb begin
    cur_tag = bus.req ? cpu_tag : pf_tag;
    bus.hit = '0;
    for (int w = 0; w < WAYS; w++) bus.hit[w] = env_vld[w] && (env_tag[w] == cur_tag);
  end
  assign bus.valid = env_vld;
  assign bus.dirty = env_dty & env_vld;

  always @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (bus.tag_write[w])   env_tag[w] <= cur_tag;
      if (bus.valid_write[w]) env_vld[w] <= bus.valid_in;
      if (bus.dirty_write[w]) env_dty[w] <= bus.dirty_in;
    end
    if (bus.pmem_read)                  rd_cyc <= rd_cyc + 1;
    if (bus.pmem_write)                 wr_cyc <= wr_cyc + 1;
    if (bus.pmem_read && bus.pmem_resp)  n_rd <= n_rd + 1;
    if (bus.pmem_write && bus.pmem_resp) n_wr <= n_wr + 1;
    if (bus.lru_update) lru_cnt <= lru_cnt + 1;
    if (bus.pf_inc)     pfinc_cnt <= pfinc_cnt + 1;
    if (bus.pf_load)     pf_tag <= cpu_tag + 1;
    else if (bus.pf_inc) pf_tag <= pf_tag + 1;
  end

  // memory: answers each strobe after 0..2 extra cycles with a 1-cycle pulse
  initial begin
    int  wait_left;
    bit  active;
    wait_left     = 0;
    active        = 1'b0;
    bus.pmem_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.pmem_resp) bus.pmem_resp = 1'b0;
      else if (!rst_n || mem_hold || !(bus.pmem_read || bus.pmem_write)) active = 1'b0;
      else begin
        if (!active) begin
          active    = 1'b1;
          wait_left = $urandom_range(0, 2);
        end
        if (wait_left == 0) begin
          bus.pmem_resp = 1'b1;
          active        = 1'b0;
        end else wait_left--;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic int m_lookup(input int t);
    for (int w = 0; w < WAYS; w++) if (m_vld[w] && m_tag[w] == t) return w;
    return -1;
  endfunction

  function automatic int m_fill_way(input int vic);
    for (int w = 0; w < WAYS; w++) if (!m_vld[w]) return w;
    return vic;
  endfunction

  task automatic check_arrays();
    logic [3:0] mv, md;
    for (int w = 0; w < WAYS; w++) begin
      mv[w] = m_vld[w];
      md[w] = m_vld[w] && m_dty[w];
      if (m_vld[w]) check("tag", env_tag[w], m_tag[w]);
    end
    check("valid_bits", env_vld, mv);
    check("dirty_bits", env_dty & env_vld, md);
  endtask

  // One CPU request; idle=1 then leaves the CPU quiet long enough for any
  // prefetch burst to finish and checks what happened in that window.
  task automatic cpu_op(input int tag, input bit rw, input int vic, input bit idle);
    int hw, way, cyc, rd0, rc0, wr0, wc0, lru0, pfi0, exp_cyc, exp_prd, exp_pwr, pv;
    bit missed, wb;
    hw = m_lookup(tag);
    missed = (hw < 0);
    wb = 1'b0;
    if (!missed) begin
      way = hw;
      exp_hits = sat(exp_hits + 1);
    end else begin
      way = m_fill_way(vic);
      wb = m_vld[way] && m_dty[way];
      m_tag[way] = tag;
      m_vld[way] = 1'b1;
      m_dty[way] = 1'b0;
      exp_miss = sat(exp_miss + 1);
    end
    if (rw) m_dty[way] = 1'b1;

    rd0 = n_rd; rc0 = rd_cyc; wr0 = n_wr; wc0 = wr_cyc;
    bus.victim_way = 2'(vic);
    cpu_tag        = tag;
    bus.readwrite  = rw;
    bus.req        = 1'b1;
    cyc            = 0;
    #1;
    while (!bus.cpu_resp && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("cpu_resp", bus.cpu_resp, 1);
    check("lru_update", bus.lru_update, 1);
    check("lru_way", bus.lru_way, way);
    @(posedge clk); #1;
    bus.req = 1'b0;
    exp_cyc = missed ? 2 + (rd_cyc - rc0) + (wb ? (wr_cyc - wc0) + 1 : 0) : 0;
    check("latency", cyc, exp_cyc);
    check("demand_reads", n_rd - rd0, missed ? 1 : 0);
    check("demand_writebacks", n_wr - wr0, wb ? 1 : 0);
    check("hit_count", bus.hit_count, exp_hits);
    check("miss_count", bus.miss_count, exp_miss);

    if (idle) begin
      pv = (vic + 1) % WAYS;
      exp_prd = 0;
      exp_pwr = 0;
`ifdef CACHE_PF_EN
      if (missed) begin
        for (int k = 1; k <= PF_DEPTH; k++) begin
          int t, fw;
          t = tag + k;
          if (m_lookup(t) < 0) begin
            fw = m_fill_way(pv);
            if (m_vld[fw] && m_dty[fw]) exp_pwr++;
            exp_prd++;
            m_tag[fw] = t;
            m_vld[fw] = 1'b1;
            m_dty[fw] = 1'b0;
            exp_pf = sat(exp_pf + 1);
          end
        end
      end
`endif
      lru0 = lru_cnt; pfi0 = pfinc_cnt; rd0 = n_rd; wr0 = n_wr;
      bus.victim_way = 2'(pv);
      repeat (40) @(posedge clk);
      #1;
      check("pf_reads", n_rd - rd0, exp_prd);
      check("pf_writebacks", n_wr - wr0, exp_pwr);
      check("pf_no_lru", lru_cnt - lru0, 0);
`ifdef CACHE_PF_EN
      check("pf_inc_pulses", pfinc_cnt - pfi0, missed ? PF_DEPTH : 0);
`else
      check("pf_inc_pulses", pfinc_cnt - pfi0, 0);
`endif
      check("pf_count", bus.pf_count, exp_pf);
    end
    check_arrays();
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req        = 1'b0;
    bus.readwrite  = 1'b0;
    bus.victim_way = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_resp", bus.cpu_resp, 0);
    check("rst_pmem_read", bus.pmem_read, 0);
    check("rst_pmem_write", bus.pmem_write, 0);
    check("rst_enables", {bus.data_writeline, bus.tag_write, bus.valid_write, bus.dirty_write}, 0);
    check("rst_misc", {bus.lru_update, bus.load_adr, bus.wb_sel, bus.adr_sel, bus.pf_load, bus.pf_inc}, 0);
    check("rst_counters", {bus.hit_count, bus.miss_count, bus.pf_count}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset landing in the middle of a refill
    mem_hold = 1'b1;
    cpu_tag  = 5;
    bus.req  = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_fill_read", bus.pmem_read, 1);
    rst_n   = 1'b0;
    bus.req = 1'b0;
    #1;
    check("rst_drops_read", bus.pmem_read, 0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    mem_hold = 1'b0;
    @(posedge clk); #1;
    check("post_rst_counters", {bus.hit_count, bus.miss_count, bus.pf_count}, 0);
    check_arrays();

    // fill ways 0..2, hit way 2, dirty way 3, then dirty-victim miss on way 3
    cpu_op(10, 1'b0, 0, 1'b1);
    cpu_op(11, 1'b0, 0, 1'b1);
    cpu_op(12, 1'b0, 0, 1'b1);
    cpu_op(12, 1'b0, 0, 1'b1);
    cpu_op(13, 1'b1, 0, 1'b1);
    cpu_op(13, 1'b1, 3, 1'b1);
    cpu_op(14, 1'b0, 3, 1'b1);
    cpu_op(14, 1'b1, 3, 1'b1);

    // saturate the hit counter
    cpu_op(20, 1'b0, 1, 1'b1);
    for (int i = 0; i < CMAX + 6; i++) cpu_op(20, i[0], 1, 1'b0);
    check("hit_saturated", bus.hit_count, CMAX);

    // random traffic
    for (int i = 0; i < 80; i++)
      cpu_op($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, WAYS - 1), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
